// File: rtl/uart_pkg.sv
// Shared UART character formatting: data-length encodings plus masking and
// parity helpers used by both the transmit and receive data paths.
package uart_pkg;

   // Widest character any instance may use; narrower characters are zero-extended.
   localparam int MAX_W = 32;

   localparam logic [1:0] LEN_M3   = 2'b00;
   localparam logic [1:0] LEN_M2   = 2'b01;
   localparam logic [1:0] LEN_M1   = 2'b10;
   localparam logic [1:0] LEN_FULL = 2'b11;

   // Keeps the low (width-3+len) bits and zeroes everything at or above that length.
   function automatic logic [MAX_W-1:0] mask_len(input logic [MAX_W-1:0] data,
                                                 input logic [1:0]       len,
                                                 input int               width);
      logic [MAX_W-1:0] m;
      int               keep;
      m    = '0;
      keep = width - 3 + int'(len);
      for (int i = 0; i < MAX_W; i++) begin
         if (i < keep) m[i] = data[i];
      end
      return m;
   endfunction

   function automatic logic calc_parity(input logic [MAX_W-1:0] masked,
                                        input logic             en,
                                        input logic             odd);
      return en ? ((^masked) ^ odd) : 1'b0;
   endfunction

endpackage

// File: rtl/uart_data_fmt.sv
// Combinational character formatter: masks to the selected length and
// produces the parity bit over the surviving bits.
module uart_data_fmt
   import uart_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] data,
   input  logic [1:0]       data_len,
   input  logic             parity_en,
   input  logic             parity_odd,
   output logic [WIDTH-1:0] masked,
   output logic             parity
);

   logic [MAX_W-1:0] wide;
   logic [MAX_W-1:0] wide_m;

   always_comb begin
      wide              = '0;
      wide[WIDTH-1:0]   = data;
   end

   assign wide_m = mask_len(wide, data_len, WIDTH);
   assign masked = wide_m[WIDTH-1:0];
   // Upper bits of wide_m are always zero, so reducing the full vector is exact.
   assign parity = calc_parity(wide_m, parity_en, parity_odd);

endmodule

// File: rtl/uart_data_fifo.sv
// UART character buffer: DEPTH entries of masked data plus a precomputed
// parity bit, first-word-fall-through read side, sticky overflow flag.
module uart_data_fifo
   import uart_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic [1:0]       data_len,
   input  logic             parity_en,
   input  logic             parity_odd,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] data_in,
   input  logic             rd_en,
   output logic [WIDTH-1:0] data_out,
   output logic             parity_out,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count,
   output logic             overflow,
   input  logic             clr_ovf
);

   logic [WIDTH:0]   mem [DEPTH];
   logic [AW-1:0]    wp;
   logic [AW-1:0]    rp;
   logic [AW:0]      cnt;
   logic [WIDTH-1:0] fmt_data;
   logic             fmt_par;
   logic             do_wr;
   logic             do_rd;

   uart_data_fmt #(.WIDTH(WIDTH)) u_fmt (
      .data       (data_in),
      .data_len   (data_len),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .masked     (fmt_data),
      .parity     (fmt_par)
   );

   // Handshake: wr_en/rd_en are requests sampled on the rising edge. A write
   // is taken when there is room or a read frees a slot in the same cycle; a
   // read is taken whenever the buffer holds data. Rejected requests are lost.
   assign do_wr = wr_en && (!full || rd_en);
   assign do_rd = rd_en && !empty;

   assign full       = (cnt == (AW+1)'(DEPTH));
   assign empty      = (cnt == '0);
   assign count      = cnt;
   assign data_out   = empty ? '0 : mem[rp][WIDTH-1:0];
   assign parity_out = empty ? 1'b0 : mem[rp][WIDTH];

   // Storage is not reset; its contents are unobservable while empty.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wp] <= {fmt_par, fmt_data};
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wp       <= '0;
         rp       <= '0;
         cnt      <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_wr) wp <= wp + AW'(1);
         if (do_rd) rp <= rp + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
         // A dropped write takes priority over a clear in the same cycle.
         if (wr_en && full && !rd_en) overflow <= 1'b1;
         else if (clr_ovf)            overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_data_fifo.sv
// Directed bench for uart_data_fifo (WIDTH=8, DEPTH=4) with hand-computed
// expectations and an ordered expected-data queue.
module tb_uart_data_fifo;

   logic       clk;
   logic       arst_n;
   logic [1:0] data_len;
   logic       parity_en;
   logic       parity_odd;
   logic       wr_en;
   logic [7:0] data_in;
   logic       rd_en;
   logic [7:0] data_out;
   logic       parity_out;
   logic       full;
   logic       empty;
   logic [2:0] count;
   logic       overflow;
   logic       clr_ovf;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q[$];

   uart_data_fifo #(.WIDTH(8), .DEPTH(4)) dut (
      .clk        (clk),
      .arst_n     (arst_n),
      .data_len   (data_len),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .wr_en      (wr_en),
      .data_in    (data_in),
      .rd_en      (rd_en),
      .data_out   (data_out),
      .parity_out (parity_out),
      .full       (full),
      .empty      (empty),
      .count      (count),
      .overflow   (overflow),
      .clr_ovf    (clr_ovf)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus: drive after the falling edge, return 1 time unit
   // after the rising edge with strobes released.
   task automatic cyc(input logic wr, input logic rd, input logic [7:0] d,
                      input logic [1:0] len, input logic pen, input logic podd,
                      input logic clr);
      @(negedge clk);
      wr_en      = wr;
      rd_en      = rd;
      data_in    = d;
      data_len   = len;
      parity_en  = pen;
      parity_odd = podd;
      clr_ovf    = clr;
      @(posedge clk);
      #1;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      clr_ovf = 1'b0;
   endtask

   task automatic push(input logic [7:0] d);
      cyc(1'b1, 1'b0, d, 2'b11, 1'b0, 1'b0, 1'b0);
   endtask

   // Checks the head against the scoreboard, then pops it.
   task automatic pop_check(input string tag);
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
      end else begin
         e = exp_q.pop_front();
         check(tag, 32'(data_out), 32'(e));
      end
      cyc(1'b0, 1'b1, 8'h00, 2'b11, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      arst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
      data_len = 2'b11; parity_en = 1'b0; parity_odd = 1'b0; clr_ovf = 1'b0;
      #12;
      check("rst_empty",    32'(empty),      32'd1);
      check("rst_full",     32'(full),       32'd0);
      check("rst_count",    32'(count),      32'd0);
      check("rst_data",     32'(data_out),   32'd0);
      check("rst_parity",   32'(parity_out), 32'd0);
      check("rst_overflow", 32'(overflow),   32'd0);
      @(negedge clk);
      arst_n = 1'b1;

      // format: 0xFF at WIDTH-1 -> 0x7F, seven ones, even parity 1
      cyc(1'b1, 1'b0, 8'hFF, 2'b10, 1'b1, 1'b0, 1'b0);
      check("fmt_data",   32'(data_out),   32'h7F);
      check("fmt_parity", 32'(parity_out), 32'd1);
      check("fmt_count",  32'(count),      32'd1);
      check("fmt_empty",  32'(empty),      32'd0);
      cyc(1'b0, 1'b1, 8'h00, 2'b11, 1'b0, 1'b0, 1'b0);
      check("fmt_pop_empty", 32'(empty), 32'd1);

      // length sweep: 0x1F odd parity (5 ones) -> 0; full width, parity off -> 0
      cyc(1'b1, 1'b0, 8'hFF, 2'b00, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 8'hFF, 2'b11, 1'b0, 1'b1, 1'b0);
      check("len_count",   32'(count),      32'd2);
      check("len_data0",   32'(data_out),   32'h1F);
      check("len_parity0", 32'(parity_out), 32'd0);
      cyc(1'b0, 1'b1, 8'h00, 2'b11, 1'b0, 1'b0, 1'b0);
      check("len_data1",   32'(data_out),   32'hFF);
      check("len_parity1", 32'(parity_out), 32'd0);
      cyc(1'b0, 1'b1, 8'h00, 2'b11, 1'b0, 1'b0, 1'b0);
      check("len_empty",   32'(empty), 32'd1);

      // fill and overflow; fifth write also asserts clr_ovf, set must win
      for (int i = 1; i <= 4; i++) begin
         push(8'(i));
         exp_q.push_back(8'(i));
      end
      check("fill_full",  32'(full),     32'd1);
      check("fill_count", 32'(count),    32'd4);
      check("fill_ovf0",  32'(overflow), 32'd0);
      cyc(1'b1, 1'b0, 8'h05, 2'b11, 1'b0, 1'b0, 1'b1);
      check("ovf_set",    32'(overflow), 32'd1);
      check("ovf_count",  32'(count),    32'd4);
      for (int i = 0; i < 4; i++) pop_check("fill_rd");
      check("fill_empty", 32'(empty),    32'd1);
      check("fill_ovf_hold", 32'(overflow), 32'd1);
      cyc(1'b0, 1'b0, 8'h00, 2'b11, 1'b0, 1'b0, 1'b1);
      check("ovf_clr",    32'(overflow), 32'd0);

      // simultaneous read and write while full
      for (int i = 1; i <= 4; i++) begin
         push(8'(i * 16));
         exp_q.push_back(8'(i * 16));
      end
      void'(exp_q.pop_front());
      exp_q.push_back(8'hAA);
      cyc(1'b1, 1'b1, 8'hAA, 2'b11, 1'b0, 1'b0, 1'b0);
      check("rw_full_count", 32'(count),    32'd4);
      check("rw_full_ovf",   32'(overflow), 32'd0);
      for (int i = 0; i < 4; i++) pop_check("rw_full_rd");
      check("rw_full_empty", 32'(empty), 32'd1);

      // simultaneous read and write while empty, then read on empty ignored
      cyc(1'b1, 1'b1, 8'h33, 2'b11, 1'b0, 1'b0, 1'b0);
      check("rw_empty_count", 32'(count),    32'd1);
      check("rw_empty_data",  32'(data_out), 32'h33);
      cyc(1'b0, 1'b1, 8'h00, 2'b11, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 8'h00, 2'b11, 1'b0, 1'b0, 1'b0);
      check("rd_empty_count", 32'(count),    32'd0);
      check("rd_empty_flag",  32'(empty),    32'd1);
      check("rd_empty_ovf",   32'(overflow), 32'd0);

      // pointer wrap over 10 write/read pairs
      for (int i = 0; i < 10; i++) begin
         push(8'h50 + 8'(i));
         exp_q.push_back(8'h50 + 8'(i));
         pop_check("wrap_rd");
      end
      check("wrap_empty", 32'(empty), 32'd1);

      // mid-operation reset with count = 3 and overflow set
      for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
      cyc(1'b0, 1'b1, 8'h00, 2'b11, 1'b0, 1'b0, 1'b0);
      check("pre_rst_count", 32'(count),    32'd3);
      check("pre_rst_ovf",   32'(overflow), 32'd1);
      @(negedge clk);
      #2;
      arst_n = 1'b0;
      #1;
      check("mid_rst_count", 32'(count),      32'd0);
      check("mid_rst_empty", 32'(empty),      32'd1);
      check("mid_rst_data",  32'(data_out),   32'd0);
      check("mid_rst_par",   32'(parity_out), 32'd0);
      check("mid_rst_ovf",   32'(overflow),   32'd0);
      @(negedge clk);
      arst_n = 1'b1;
      cyc(1'b1, 1'b0, 8'h3C, 2'b11, 1'b1, 1'b1, 1'b0);
      check("post_rst_data", 32'(data_out),   32'h3C);
      check("post_rst_par",  32'(parity_out), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
